// File: rtl/lsu_bus_pkg.sv
// Shared definitions for the LSU data-SRAM bus master.
// Holds the master FSM state encoding, access-size encodings, bus geometry
// constants and small helpers for alignment checks and store strobes.
package lsu_bus_pkg;

    localparam int unsigned BUS_DATA_W = 64;
    localparam int unsigned BUS_BYTES  = BUS_DATA_W / 8;
    localparam int unsigned OFF_W      = $clog2(BUS_BYTES);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AR     = 3'd1,
        R_WAIT = 3'd2,
        AW_W   = 3'd3,
        B_WAIT = 3'd4,
        RESP   = 3'd5
    } state_t;

    // Byte offset is not a multiple of the access size.
    function automatic logic misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = |off[1:0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

    // Lane-0 byte-enable mask for an access of the given size.
    function automatic logic [BUS_BYTES-1:0] strb_mask(input logic [1:0] size);
        logic [BUS_BYTES-1:0] m;
        case (size)
            SZ_B:    m = BUS_BYTES'(8'h01);
            SZ_H:    m = BUS_BYTES'(8'h03);
            SZ_W:    m = BUS_BYTES'(8'h0F);
            default: m = BUS_BYTES'(8'hFF);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: shifts the addressed byte lane down to bit 0, truncates
// to the access size and sign- or zero-extends to the full bus width.
// Ports: rdata (bus beat), off (byte offset in beat), size (SZ_*),
//        is_signed (sign-extend), result_c (combinational result).
module lsu_load_align
    import lsu_bus_pkg::*;
#(
    parameter int unsigned DATA_W = BUS_DATA_W
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              is_signed,
    output logic [DATA_W-1:0] result_c
);

    logic [DATA_W-1:0] lane;

    always_comb begin
        lane     = rdata >> {off, 3'b000};
        result_c = lane;
        case (size)
            SZ_B:    result_c = {{(DATA_W-8){is_signed & lane[7]}},   lane[7:0]};
            SZ_H:    result_c = {{(DATA_W-16){is_signed & lane[15]}}, lane[15:0]};
            SZ_W:    result_c = {{(DATA_W-32){is_signed & lane[31]}}, lane[31:0]};
            default: result_c = lane;
        endcase
    end

endmodule

// File: rtl/lsu_axi_master.sv
// LSU data-SRAM bus initiator. Accepts one load/store at a time from the
// pipeline, drives the AR/R or AW/W/B channels, aligns load data, builds
// store strobes and returns a one-cycle completion pulse.
// Ports: clock, rst_n (synchronous, active-low)
//        req_*  : pipeline request (valid/ready, wen, addr, size, signed, wdata)
//        resp_* : completion pulse, extended load data, error flag
//        ar*/r* : read address / read data channels
//        aw*/w*/b* : write address / write data / write response channels
// Optional: define LSU_TIMEOUT_EN to enable a TIMEOUT_CYCLES watchdog that
// aborts a stalled transaction with resp_err.
module lsu_axi_master
    import lsu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic                bresp,
    input  logic                bvalid,
    output logic                bready
);

    if (DATA_W != BUS_DATA_W || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("lsu_axi_master: unsupported DATA_W or TIMEOUT_CYCLES");
    end

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              err_d;
    logic              timeout_c;
    logic [DATA_W-1:0] load_c;

    logic              arvalid_d, awvalid_d, wvalid_d, req_ready_d, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_d;

    logic [OFF_W-1:0]  req_off;
    logic [ADDR_W-1:0] req_base;
    logic              ar_hs, aw_hs, w_hs;
    logic              unused_ok;

    assign req_off   = req_addr[OFF_W-1:0];
    assign req_base  = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign ar_hs     = arvalid & arready;
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign rready    = 1'b1;
    assign bready    = 1'b1;
    assign unused_ok = &{1'b0, rvalid, bvalid};

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             busy_c;

    assign busy_c = state_q inside {AR, R_WAIT, AW_W, B_WAIT};

    // Cycle counter for the in-flight transaction; idle holds it at zero so it
    // always starts cleared on entry to AR or AW_W.
    always_ff @(posedge clock) begin
        if (!rst_n || state_q == IDLE) tmo_cnt_q <= '0;
        else if (busy_c)               tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end

    assign timeout_c = busy_c && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    lsu_load_align #(.DATA_W(DATA_W)) u_align (
        .rdata     (rdata),
        .off       (off_q),
        .size      (size_q),
        .is_signed (signed_q),
        .result_c  (load_c)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and write-channel handshake tracking.
    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (req_valid) begin
                    if (misaligned(req_off, req_size)) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else if (req_wen) begin
                        state_d = AW_W;
                    end else begin
                        state_d = AR;
                    end
                end
            end
            AR:     if (ar_hs) state_d = R_WAIT;
            R_WAIT: if (rresp) state_d = RESP;
            AW_W: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) state_d = B_WAIT;
            end
            B_WAIT: if (bresp) state_d = RESP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A completing response in the same cycle wins over the watchdog.
        if (timeout_c && state_d != RESP) begin
            state_d = RESP;
            err_d   = 1'b1;
        end
    end

    // Next values of the registered handshake and response outputs.
    always_comb begin
        arvalid_d    = (state_d == AR);
        awvalid_d    = (state_d == AW_W) && !aw_done_d;
        wvalid_d     = (state_d == AW_W) && !w_done_d;
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        resp_rdata_d = resp_rdata;
        if (state_q == R_WAIT && rresp)               resp_rdata_d = load_c;
        else if (state_d == RESP && state_q != RESP)  resp_rdata_d = '0;
    end

    // Output and request-latch registers.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            arvalid    <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            araddr     <= '0;
            awaddr     <= '0;
            wdata      <= '0;
            wstrb      <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            off_q      <= '0;
            size_q     <= SZ_B;
            signed_q   <= 1'b0;
        end else begin
            arvalid    <= arvalid_d;
            awvalid    <= awvalid_d;
            wvalid     <= wvalid_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= err_d;
            resp_rdata <= resp_rdata_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            if (state_q == IDLE && req_valid) begin
                off_q    <= req_off;
                size_q   <= req_size;
                signed_q <= req_signed;
                if (state_d == AR) araddr <= req_base;
                if (state_d == AW_W) begin
                    awaddr <= req_base;
                    wdata  <= req_wdata << {req_off, 3'b000};
                    wstrb  <= strb_mask(req_size) << req_off;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed self-checking bench for lsu_axi_master. Inputs change 1 ns after
// the rising edge; outputs are sampled at that same point.
module tb_lsu_axi_master;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen, req_signed;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic [31:0] araddr, awaddr;
    logic        arvalid, arready, rresp, rvalid, rready;
    logic [63:0] rdata, wdata;
    logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;
    logic [7:0]  wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lsu_axi_master #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one cycle; the master is idle so it is accepted.
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] wd);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
    endtask

    // Load against an always-ready SRAM returning rd one cycle after AR.
    task automatic load_fast(input string tag, input logic [31:0] addr, input logic [1:0] size,
                             input logic sgn, input logic [63:0] rd, input logic [63:0] exp);
        arready = 1'b1;
        issue(1'b0, addr, size, sgn, 64'h0);
        chk({tag, "_arvalid"}, arvalid, 1);
        chk({tag, "_araddr"}, araddr, {addr[31:3], 3'b000});
        chk({tag, "_busy"}, req_ready, 0);
        tick();
        chk({tag, "_arvalid_drop"}, arvalid, 0);
        rdata = rd;
        rresp = 1'b1;
        tick();
        rresp = 1'b0;
        chk({tag, "_resp_valid"}, resp_valid, 1);
        chk({tag, "_rdata"}, resp_rdata, exp);
        chk({tag, "_err"}, resp_err, 0);
        tick();
        chk({tag, "_pulse_end"}, resp_valid, 0);
        chk({tag, "_ready"}, req_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0;
        req_signed = 0; req_wdata = 0; arready = 1; rdata = 0; rresp = 0;
        rvalid = 1; awready = 1; wready = 1; bresp = 0; bvalid = 1;
        tick();
        tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_rready", rready, 1);
        chk("rst_bready", bready, 1);
        chk("rst_araddr", araddr, 0);
        chk("rst_wstrb", wstrb, 0);
        rst_n = 1'b1;
        tick();

        load_fast("lb",  32'h80000003, 2'd0, 1'b1, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFF89);
        load_fast("lhu", 32'h80000002, 2'd1, 1'b0, 64'h0123456789ABCDEF, 64'h00000000000089AB);
        load_fast("lbu", 32'h80000000, 2'd0, 1'b0, 64'h0123456789ABCDEF, 64'h00000000000000EF);
        load_fast("lh",  32'h80000006, 2'd1, 1'b1, 64'h0123456789ABCDEF, 64'h0000000000000123);
        load_fast("ld",  32'h80000018, 2'd3, 1'b1, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210);

        // sw at offset 4, all channels ready.
        issue(1'b1, 32'h80000004, 2'd2, 1'b0, 64'h00000000DEADBEEF);
        chk("sw_awvalid", awvalid, 1);
        chk("sw_wvalid", wvalid, 1);
        chk("sw_arvalid", arvalid, 0);
        chk("sw_awaddr", awaddr, 64'h80000000);
        chk("sw_wdata", wdata, 64'hDEADBEEF00000000);
        chk("sw_wstrb", wstrb, 64'hF0);
        tick();
        chk("sw_awvalid_drop", awvalid, 0);
        chk("sw_wvalid_drop", wvalid, 0);
        chk("sw_no_early_resp", resp_valid, 0);
        bresp = 1'b1;
        tick();
        bresp = 1'b0;
        chk("sw_resp_valid", resp_valid, 1);
        chk("sw_rdata_zero", resp_rdata, 0);
        chk("sw_err", resp_err, 0);
        tick();
        chk("sw_pulse_end", resp_valid, 0);

        // sd with both write channels stalled; wready rises before awready.
        awready = 1'b0;
        wready  = 1'b0;
        issue(1'b1, 32'h80000008, 2'd3, 1'b0, 64'h1122334455667788);
        for (int i = 0; i < 3; i++) begin
            chk("sd_awvalid_hold", awvalid, 1);
            chk("sd_wvalid_hold", wvalid, 1);
            tick();
        end
        wready = 1'b1;
        tick();
        wready = 1'b0;
        chk("sd_wvalid_drop", wvalid, 0);
        chk("sd_awvalid_still", awvalid, 1);
        chk("sd_awaddr", awaddr, 64'h80000008);
        chk("sd_wdata", wdata, 64'h1122334455667788);
        chk("sd_wstrb", wstrb, 64'hFF);
        awready = 1'b1;
        tick();
        chk("sd_awvalid_drop", awvalid, 0);
        chk("sd_no_early_resp", resp_valid, 0);
        bresp = 1'b1;
        tick();
        bresp = 1'b0;
        chk("sd_resp_valid", resp_valid, 1);
        chk("sd_err", resp_err, 0);
        tick();
        chk("sd_single_pulse", resp_valid, 0);
        wready = 1'b1;

        // lw with arready stalled, then a slow read response.
        arready = 1'b0;
        issue(1'b0, 32'h80000000, 2'd2, 1'b1, 64'h0);
        for (int i = 0; i < 3; i++) begin
            chk("lw_arvalid_hold", arvalid, 1);
            chk("lw_araddr_hold", araddr, 64'h80000000);
            tick();
        end
        arready = 1'b1;
        tick();
        chk("lw_arvalid_drop", arvalid, 0);
        tick();
        chk("lw_waiting", resp_valid, 0);
        rdata = 64'h0123456789ABCDEF;
        rresp = 1'b1;
        tick();
        rresp = 1'b0;
        chk("lw_resp_valid", resp_valid, 1);
        chk("lw_rdata", resp_rdata, 64'hFFFFFFFF89ABCDEF);
        tick();
        chk("lw_pulse_end", resp_valid, 0);

        // Misaligned lw and sh: error response the cycle after accept, no bus traffic.
        issue(1'b0, 32'h80000002, 2'd2, 1'b0, 64'h0);
        chk("mis_lw_resp_valid", resp_valid, 1);
        chk("mis_lw_err", resp_err, 1);
        chk("mis_lw_rdata", resp_rdata, 0);
        chk("mis_lw_arvalid", arvalid, 0);
        chk("mis_lw_awvalid", awvalid, 0);
        tick();
        chk("mis_lw_pulse_end", resp_valid, 0);
        chk("mis_lw_err_clear", resp_err, 0);
        chk("mis_lw_arvalid_after", arvalid, 0);
        issue(1'b1, 32'h80000001, 2'd1, 1'b0, 64'hFFFF);
        chk("mis_sh_err", resp_err, 1);
        chk("mis_sh_awvalid", awvalid, 0);
        chk("mis_sh_wvalid", wvalid, 0);
        tick();

        // Stray responses while idle are ignored.
        rresp = 1'b1;
        bresp = 1'b1;
        tick();
        rresp = 1'b0;
        bresp = 1'b0;
        chk("stray_resp_valid", resp_valid, 0);
        chk("stray_ready", req_ready, 1);

`ifdef LSU_TIMEOUT_EN
        // Read response never arrives: watchdog fires after 8 in-flight cycles.
        arready = 1'b1;
        issue(1'b0, 32'h80000010, 2'd2, 1'b0, 64'h0);
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_not_yet", resp_valid, 0);
        tick();
        chk("tmo_resp_valid", resp_valid, 1);
        chk("tmo_err", resp_err, 1);
        chk("tmo_rdata", resp_rdata, 0);
        chk("tmo_arvalid", arvalid, 0);
        tick();
        chk("tmo_pulse_end", resp_valid, 0);
`endif

        // Reset in the middle of a stalled store abandons it.
        awready = 1'b0;
        wready  = 1'b0;
        issue(1'b1, 32'h80000004, 2'd2, 1'b0, 64'h00000000CAFEF00D);
        tick();
        chk("rst_mid_awvalid_before", awvalid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_awvalid", awvalid, 0);
        chk("rst_mid_wvalid", wvalid, 0);
        chk("rst_mid_awaddr", awaddr, 0);
        chk("rst_mid_wdata", wdata, 0);
        chk("rst_mid_wstrb", wstrb, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_resp_valid", resp_valid, 0);
        awready = 1'b1;
        wready  = 1'b1;
        bresp   = 1'b1;
        tick();
        bresp   = 1'b0;
        chk("rst_mid_no_resp", resp_valid, 0);
        load_fast("post_rst", 32'h80000001, 2'd0, 1'b1, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
Initiator side of the LSU data-SRAM bus. It accepts one load or store request at a time from the pipeline LSU stage and drives the five read/write channels toward the data SRAM responder. For loads it aligns, extracts and sign-/zero-extends the returned data; for stores it builds byte strobes. It returns a single-cycle completion pulse to the pipeline.

Parameters:
ADDR_W, 32, bus and request address width
DATA_W, 64, bus data width; bytes per beat = DATA_W/8
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined

Ports:
clock  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  pipeline request valid
req_ready  out  1  master idle and able to accept a request
req_wen  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
req_signed  in  1  sign-extend the load result
req_wdata  in  64  store data, LSB-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  64  extended load data; 0 for stores
resp_err  out  1  qualifies resp_valid: misaligned access or timeout
araddr  out  32  8-byte-aligned read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  64  read data
rresp  in  1  read data beat strobe, high one cycle
rvalid  in  1  ignored (responder ties it high)
rready  out  1  held at 1
awaddr  out  32  8-byte-aligned write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  64  lane-shifted store data
wstrb  out  8  byte strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  1  write completion strobe, high one cycle
bvalid  in  1  ignored
bready  out  1  held at 1

Behaviour:
- Reset: state IDLE; arvalid/awvalid/wvalid/resp_valid/resp_err = 0; req_ready = 1; rready = bready = 1; araddr/awaddr/wdata/wstrb/resp_rdata = 0. Reset mid-transaction abandons the transaction with no response.
- Request accept: req_valid && req_ready in IDLE. Latch addr, size, signed, wen and wdata. req_ready = 1 only in IDLE.
- Misalign check: addr[2:0] not a multiple of 2^size → go to RESP with resp_err = 1. No bus activity.
- Alignment: bus address = {addr[31:3], 3'b000}. off = addr[2:0].
- Store data: wdata = req_wdata << (8*off). wstrb = ((1<<(1<<size))-1) << off. Examples: sw at off 4 gives wstrb 0xF0; sd gives 0xFF.
- States: IDLE → AR → R_WAIT → RESP for loads; IDLE → AW_W → B_WAIT → RESP for stores; RESP → IDLE.
- AR: arvalid = 1 until the cycle in which arvalid && arready is sampled; arvalid drops the next cycle. Go to R_WAIT.
- R_WAIT: on rresp = 1, capture rdata. Extract the byte lane as rdata >> (8*off), truncate to size, then extend per req_signed. Go to RESP.
- AW_W: awvalid and wvalid assert together. Each drops independently after its own handshake. Go to B_WAIT once both have handshaken; same-cycle handshakes are allowed.
- B_WAIT: on bresp = 1, go to RESP with resp_rdata = 0.
- RESP: resp_valid = 1 for exactly one cycle. There is no backpressure: the pipeline must consume the pulse. The next request can be accepted the cycle after RESP.
- A rresp or bresp arriving in any other state is ignored.
- Latency with an always-ready SRAM: load = 4 cycles from accept to resp_valid (AR, wait, capture, RESP); store = 4 cycles.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter clears on entry to AR or AW_W and increments in AR, R_WAIT, AW_W and B_WAIT. When it reaches TIMEOUT_CYCLES: deassert all valids, go to RESP with resp_err = 1, resp_rdata = 0.
- Undefined: no counter; the master waits indefinitely.

Decomposition:
- Package lsu_bus_pkg holds:
  - state enum (IDLE, AR, R_WAIT, AW_W, B_WAIT, RESP);
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - DATA_W/8 constant.
- Sub-module lsu_load_align: combinational lane extraction plus sign/zero extension (rdata, off, size, signed → 64-bit result). It is shared later with the ifetch path.

Test Plan:
- lb signed, addr 0x80000003, SRAM data 0x0123456789ABCDEF → araddr 0x80000000, resp_rdata 0xFFFFFFFFFFFFFF89, resp_err 0.
- lhu, addr 0x80000002, same data → resp_rdata 0x00000000000089AB. Check arvalid high exactly one cycle when arready = 1.
- sw, data 0xDEADBEEF, addr 0x80000004 → awaddr 0x80000000, wdata 0xDEADBEEF00000000, wstrb 0xF0; resp_valid after bresp, resp_rdata 0.
- arready/awready/wready held low 3 cycles, wready rising before awready → valids held stable until each handshake; single resp_valid.
- lw at 0x80000002 → resp_err = 1 the cycle after accept; arvalid/awvalid never asserted.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES = 8, rresp never sent → resp_valid & resp_err after 8 cycles; then assert rst_n = 0 during a store → all outputs return to reset values next edge.
